// File: rtl/wb_flash_copy.sv
// rtl/wb_flash_copy.sv - Wishbone master copying a word block from flash to another slave.
// Optional FLASH_COPY_CHECKSUM_EN adds checksum_o, the running sum of words read.
module wb_flash_copy #(
    parameter int LEN_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
`ifdef FLASH_COPY_CHECKSUM_EN
    output logic [31:0]      checksum_o,
`endif
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [31:0]      wbm_adr_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic             wbm_rty_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_GAP_W, S_WR, S_GAP_R, S_DONE
    } state_t;

    state_t           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_cyc;
    logic             r_stb;
    logic             r_we;
    logic [31:0]      r_adr;
    logic [31:0]      r_dat;
`ifdef FLASH_COPY_CHECKSUM_EN
    logic [31:0]      r_sum;
`endif

    logic [31:0] w_src_al;
    logic [31:0] w_dst_al;

    assign w_src_al = src_i & ~32'h3;
    assign w_dst_al = dst_i & ~32'h3;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
`ifdef FLASH_COPY_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_src  <= w_src_al;
                        r_dst  <= w_dst_al;
                        r_cnt  <= len_i;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
`ifdef FLASH_COPY_CHECKSUM_EN
                        r_sum  <= '0;
`endif
                        if (len_i == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_we    <= 1'b0;
                            r_adr   <= w_src_al;
                            r_state <= S_RD;
                        end
                    end
                end
                // Any response drops cyc/stb on the next edge so the slave sees an idle cycle.
                S_RD: begin
                    if (wbm_err_i) begin
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (wbm_ack_i) begin
                        r_dat   <= wbm_dat_i;
`ifdef FLASH_COPY_CHECKSUM_EN
                        r_sum   <= r_sum + wbm_dat_i;
`endif
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= S_GAP_W;
                    end else if (wbm_rty_i) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= S_GAP_R;
                    end
                end
                S_GAP_W: begin
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we    <= 1'b1;
                    r_adr   <= r_dst;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (wbm_err_i) begin
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (wbm_ack_i) begin
                        r_src <= r_src + 32'd4;
                        r_dst <= r_dst + 32'd4;
                        r_cnt <= r_cnt - LEN_W'(1);
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        if (r_cnt == LEN_W'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_GAP_R;
                        end
                    end else if (wbm_rty_i) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= S_GAP_W;
                    end
                end
                S_GAP_R: begin
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we    <= 1'b0;
                    r_adr   <= r_src;
                    r_state <= S_RD;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign wbm_cyc_o  = r_cyc;
    assign wbm_stb_o  = r_stb;
    assign wbm_we_o   = r_we;
    assign wbm_adr_o  = r_adr;
    assign wbm_sel_o  = 4'hF;
    assign wbm_dat_o  = r_dat;
`ifdef FLASH_COPY_CHECKSUM_EN
    assign checksum_o = r_sum;
`endif

endmodule

// File: tb/tb_wb_flash_copy.sv
// tb/tb_wb_flash_copy.sv - scoreboard bench for wb_flash_copy with a latency/fault-injecting slave.
module tb_wb_flash_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src, dst;
    logic [15:0] len;
    logic        busy, done, err_o;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        ack, err, rty;
`ifdef FLASH_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    wb_flash_copy #(.LEN_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
        .src_i(src), .dst_i(dst), .len_i(len),
        .busy_o(busy), .done_o(done), .err_o(err_o),
`ifdef FLASH_COPY_CHECKSUM_EN
        .checksum_o(checksum),
`endif
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_adr_o(adr), .wbm_sel_o(sel), .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=event required=no_event", nm);
    endtask

    typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;
    typedef struct { logic err; logic [31:0] sum; logic zl; } dn_t;
    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    dn_t         dn_q[$];

    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    function automatic logic [31:0] fill(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Slave model: configurable latencies, registered one-cycle responses, one-shot faults.
    int rd_lat = 1, wr_lat = 1;
    int rty_rd_word = 0, rty_wr_word = 0, err_rd_word = 0, err_wr_word = 0;
    int rd_acks = 0, wr_acks = 0, s_cnt = 0;
    bit rty_used = 0;

    initial begin
        ack = 0; err = 0; rty = 0; dat_i = 0;
        forever begin
            @(posedge clk); #1;
            if (rst || ack || err || rty) begin
                ack = 0; err = 0; rty = 0; s_cnt = 0;
            end else if (cyc && stb) begin
                s_cnt++;
                if (s_cnt >= (we ? wr_lat : rd_lat)) begin
                    s_cnt = 0;
                    if (!we) begin
                        if (rd_acks + 1 == err_rd_word) begin
                            err = 1; ack = 1;
                        end else if (rd_acks + 1 == rty_rd_word && !rty_used) begin
                            rty = 1; rty_used = 1;
                        end else begin
                            ack = 1;
                            dat_i = mem.exists(adr) ? mem[adr] : fill(adr);
                            rd_acks++;
                        end
                    end else begin
                        if (wr_acks + 1 == err_wr_word) begin
                            err = 1; ack = 1; rty = 1;
                        end else if (wr_acks + 1 == rty_wr_word && !rty_used) begin
                            rty = 1; rty_used = 1;
                        end else begin
                            ack = 1;
                            mem[adr] = dat_o;
                            wr_acks++;
                        end
                    end
                end
            end else begin
                s_cnt = 0;
            end
        end
    end

    int cyc_n = 0;
    initial forever begin @(posedge clk); cyc_n++; end

    // Monitor: pops the scoreboard whenever the bus or done_o presents a result.
    int done_cnt = 0, start_cyc = 0, last_resp_cyc = 0, rty_hits = 0, rty_wait = 0;
    bit resp_prev = 0, done_prev = 0, cyc_seen = 0;
    logic [31:0] rty_adr = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("sel", {28'd0, sel}, 32'hF);
            chk("adr_align", {30'd0, adr[1:0]}, 32'd0);
            if (cyc) cyc_seen = 1;
            if (resp_prev) chk("gap_after_resp", {31'd0, cyc}, 32'd0);
            if (rty_wait == 1) begin
                chk("rty_reissue_stb", {31'd0, cyc & stb}, 32'd1);
                chk("rty_reissue_adr", adr, rty_adr);
            end
            if (rty_wait > 0) rty_wait--;
            if (done_prev) chk("busy_after_done", {31'd0, busy}, 32'd0);
            resp_prev = cyc && stb && (ack || err || rty);
            if (cyc && stb && (ack || err || rty)) begin
                if (err) begin
                    last_resp_cyc = cyc_n;
                end else if (ack && !we) begin
                    last_resp_cyc = cyc_n;
                    if (rd_q.size() == 0) fail("rd_unexpected");
                    else chk("rd_adr", adr, rd_q.pop_front());
                end else if (ack && we) begin
                    wr_t w;
                    last_resp_cyc = cyc_n;
                    if (wr_q.size() == 0) fail("wr_unexpected");
                    else begin
                        w = wr_q.pop_front();
                        chk("wr_adr", adr, w.adr);
                        chk("wr_dat", dat_o, w.dat);
                    end
                end else begin
                    rty_hits++;
                    rty_adr = adr;
                    rty_wait = 2;
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_in_done", {31'd0, busy}, 32'd1);
                if (dn_q.size() == 0) fail("done_unexpected");
                else begin
                    dn_t e;
                    e = dn_q.pop_front();
                    chk("err_o", {31'd0, err_o}, {31'd0, e.err});
`ifdef FLASH_COPY_CHECKSUM_EN
                    chk("checksum", checksum, e.sum);
`endif
                    if (e.zl) chk("done_lat_len0", cyc_n - start_cyc, 0);
                    else      chk("done_lat", cyc_n - last_resp_cyc, 1);
                    chk("rd_left", rd_q.size(), 0);
                    chk("wr_left", wr_q.size(), 0);
                end
            end
            done_prev = done;
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    // Reference model: word-by-word copy semantics with the requested fault applied.
    task automatic model(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] as, ad, ra, wa, v, sum;
        logic e;
        as = s & ~32'h3; ad = d & ~32'h3; sum = 0; e = 0;
        for (int i = 0; i < n; i++) begin
            ra = as + 32'(4 * i);
            if (err_rd_word == i + 1) begin e = 1; break; end
            v = ref_rd(ra);
            rd_q.push_back(ra);
            sum += v;
            if (err_wr_word == i + 1) begin e = 1; break; end
            wa = ad + 32'(4 * i);
            ref_mem[wa] = v;
            wr_q.push_back('{wa, v});
        end
        dn_q.push_back('{e, sum, (n == 0)});
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n);
        rd_acks = 0; wr_acks = 0; rty_used = 0;
        model(s, d, n);
        @(negedge clk);
        src = s; dst = d; len = 16'(n); start = 1;
        @(posedge clk); #1;
        start = 0;
        start_cyc = cyc_n;
        src = $urandom; dst = $urandom; len = 16'($urandom_range(1, 9));
        chk("busy_start", {31'd0, busy}, 32'd1);
        chk("cyc_start", {31'd0, cyc & stb}, (n > 0) ? 32'd1 : 32'd0);
        if (n > 0) begin
            chk("we_start", {31'd0, we}, 32'd0);
            chk("adr_start", adr, s & ~32'h3);
        end
    endtask

    task automatic wait_done(input int t0, input bit poke);
        int k = 0;
        if (poke) begin
            repeat (4) @(negedge clk);
            if (busy) begin
                start = 1; src = 32'h0BAD_0000; dst = 32'h0BAD_1000; len = 16'd7;
                @(negedge clk);
                start = 0;
            end
        end
        while (done_cnt == t0 && k < 20000) begin @(posedge clk); k++; end
        if (done_cnt == t0) fail("done_timeout");
        repeat (3) @(posedge clk);
        chk("done_pulses", done_cnt - t0, 1);
    endtask

    task automatic copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit poke);
        int t0;
        t0 = done_cnt;
        issue(s, d, n);
        wait_done(t0, poke);
        rty_rd_word = 0; rty_wr_word = 0; err_rd_word = 0; err_wr_word = 0;
    endtask

    initial begin
        int t0, k;
        logic [31:0] rs, rd;
        rst = 1; start = 0; src = 0; dst = 0; len = 0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'd0, cyc}, 0);
        chk("rst_stb", {31'd0, stb}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err_o}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_o, 0);
        rst = 0;

        // Slow flash read, fast RAM write, three known words.
        rd_lat = 12; wr_lat = 1;
        mem[32'h0400_0000] = 32'h1122_3344; ref_mem[32'h0400_0000] = 32'h1122_3344;
        mem[32'h0400_0004] = 32'h5566_7788; ref_mem[32'h0400_0004] = 32'h5566_7788;
        mem[32'h0400_0008] = 32'h99AA_BBCC; ref_mem[32'h0400_0008] = 32'h99AA_BBCC;
        copy(32'h0400_0000, 32'h0000_1000, 3, 1'b1);
        chk("ram0", mem[32'h1000], 32'h1122_3344);
        chk("ram1", mem[32'h1004], 32'h5566_7788);
        chk("ram2", mem[32'h1008], 32'h99AA_BBCC);

        // Zero length: no bus activity, busy for a single cycle.
        rd_lat = 2; wr_lat = 2;
        cyc_seen = 0;
        copy(32'h0400_0000, 32'h0000_2000, 0, 1'b0);
        chk("len0_no_cyc", {31'd0, cyc_seen}, 0);

        // Misaligned source, address wrap.
        copy(32'h0400_0003, 32'h0000_3002, 2, 1'b0);
        copy(32'hFFFF_FFFC, 32'h0000_4000, 3, 1'b0);

        // Retry on the second read.
        rty_hits = 0; rty_rd_word = 2;
        copy(32'h0500_0000, 32'h0000_5000, 3, 1'b0);
        chk("rty_once", rty_hits, 1);
        chk("rty_adr", rty_adr, 32'h0500_0004);

        // Error (with ack and rty also high) on the write of word 2 of 4.
        err_wr_word = 2;
        copy(32'h0600_0000, 32'h3000_0000, 4, 1'b0);
        chk("err_w1", mem.exists(32'h3000_0000) ? 32'd1 : 32'd0, 32'd1);
        chk("err_no_w2", mem.exists(32'h3000_0004) ? 32'd1 : 32'd0, 32'd0);
        chk("err_no_w4", mem.exists(32'h3000_000C) ? 32'd1 : 32'd0, 32'd0);

        // Reset during the read of word 2.
        rd_lat = 12; wr_lat = 1;
        t0 = done_cnt;
        issue(32'h0700_0000, 32'h3100_0000, 4);
        k = 0;
        while (!(cyc && stb && !we && adr == 32'h0700_0004) && k < 2000) begin
            @(negedge clk); k++;
        end
        if (k >= 2000) fail("reach_rd2_timeout");
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_rst_cyc", {31'd0, cyc}, 0);
        chk("mid_rst_stb", {31'd0, stb}, 0);
        chk("mid_rst_we", {31'd0, we}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        chk("mid_rst_adr", adr, 0);
        chk("mid_rst_dat", dat_o, 0);
        rd_q.delete(); wr_q.delete(); dn_q.delete();
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - t0, 0);
        copy(32'h0700_0000, 32'h3200_0000, 4, 1'b1);

        // Randomized copies with random latencies and faults.
        for (int it = 0; it < 16; it++) begin
            int n, f;
            rd_lat = $urandom_range(1, 4);
            wr_lat = $urandom_range(1, 4);
            n = $urandom_range(1, 6);
            rs = $urandom;
            rd = 32'h2000_0000 + 32'(it * 256) + 32'($urandom_range(0, 3));
            f = $urandom_range(0, 5);
            case (f)
                1: rty_rd_word = $urandom_range(1, n);
                2: rty_wr_word = $urandom_range(1, n);
                3: err_rd_word = $urandom_range(1, n);
                4: err_wr_word = $urandom_range(1, n);
                default: ;
            endcase
            copy(rs, rd, n, ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
